// File: rtl/alu_pipe_hs_pkg.sv
// Shared opcodes, flag bundle and multiplier FSM states for alu_pipe_hs.
package alu_pipe_hs_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_ROR  = 4'd4;
  localparam logic [3:0] OP_SNE  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_SGE  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic sign;
    logic ovf;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_hs_mul.sv
// Iterative shift-add unsigned multiplier (alu_mul_iter), one multiplier bit per cycle.
// Compiled only when ALU_PIPE_HS_MUL_EN is defined.
`ifdef ALU_PIPE_HS_MUL_EN
module alu_mul_iter
  import alu_pipe_hs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             take,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH);

  mul_state_e         state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     partial;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MUL_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      MUL_IDLE: if (start) state_nxt = MUL_RUN;
      MUL_RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = MUL_DONE;
      MUL_DONE: if (take) state_nxt = MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  // acc = {partial high half, unconsumed multiplier bits}; each step adds then shifts right.
  assign partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (state == MUL_IDLE && start) begin
      cnt   <= '0;
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (state == MUL_RUN) begin
      cnt   <= cnt + CW'(1);
      acc   <= {partial, acc[WIDTH-1:1]};
    end
  end

  assign busy    = (state == MUL_RUN);
  assign done    = (state == MUL_DONE);
  assign product = acc[WIDTH-1:0];
  assign carry   = |acc[2*WIDTH-1:WIDTH];

endmodule
`endif

// File: rtl/alu_pipe_hs.sv
// Two-stage ALU with valid/ready handshakes on both sides.
// Define ALU_PIPE_HS_MUL_EN to add the iterative MUL; otherwise opcode 2 is illegal.
module alu_pipe_hs
  import alu_pipe_hs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shiftValue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             signFlag,
  output logic             ovfFlag,
  output logic             illegalFlag
);

  logic             run_q;
  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [SHW-1:0]   s1_sh, rol_amt;
  alu_flags_t       flags_q, alu_flags, mul_flags;
  logic [WIDTH-1:0] alu_res, mul_res;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic             s1_is_mul, mul_busy, out_free, alu_fire, mul_fire, accept;

  assign out_free = !out_valid || out_ready;
  assign alu_fire = s1_valid && !s1_is_mul && out_free;
  assign in_ready = run_q && !mul_busy && (!s1_valid || alu_fire);
  assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_HS_MUL_EN
  logic mul_done, mul_carry;

  assign s1_is_mul = (s1_op == OP_MUL);
  assign mul_fire  = s1_valid && s1_is_mul && mul_done && out_free;
  assign mul_flags = '{carry: mul_carry, zero: (mul_res == '0), sign: mul_res[WIDTH-1],
                       ovf: 1'b0, illegal: 1'b0};

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (s1_valid && s1_is_mul),
    .take    (out_free),
    .a       (s1_a),
    .b       (s1_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_res),
    .carry   (mul_carry)
  );
`else
  assign s1_is_mul = 1'b0;
  assign mul_busy  = 1'b0;
  assign mul_fire  = 1'b0;
  assign mul_res   = '0;
  assign mul_flags = '0;
`endif

  // Rotate-left by s equals rotate-right by -s mod WIDTH.
  assign rol_amt = '0 - s1_sh;

  // NOTE: every output is given a default first, so no path leaves a latch behind.
  always_comb begin
    add_sum   = {1'b0, s1_a} + {1'b0, s1_b};
    sub_diff  = s1_a - s1_b;
    alu_res   = '0;
    alu_flags = '0;
    case (s1_op)
      OP_ADD: begin
        alu_res         = add_sum[WIDTH-1:0];
        alu_flags.carry = add_sum[WIDTH];
        alu_flags.ovf   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (add_sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res         = sub_diff;
        alu_flags.carry = (s1_a < s1_b);
        alu_flags.ovf   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (sub_diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(s1_a) < $signed(s1_b)};
      OP_SGE:  alu_res = {{(WIDTH-1){1'b0}}, $signed(s1_a) >= $signed(s1_b)};
      OP_SNE:  alu_res = {{(WIDTH-1){1'b0}}, s1_a != s1_b};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, s1_a < s1_b};
      OP_AND:  alu_res = s1_a & s1_b;
      OP_OR:   alu_res = s1_a | s1_b;
      OP_XOR:  alu_res = s1_a ^ s1_b;
      OP_ROR:  alu_res = WIDTH'({s1_a, s1_a} >> s1_sh);
      OP_ROL:  alu_res = WIDTH'({s1_a, s1_a} >> rol_amt);
      default: alu_flags.illegal = 1'b1;
    endcase
    alu_flags.zero = (alu_res == '0);
    alu_flags.sign = alu_res[WIDTH-1];
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run_q <= 1'b0;
    else      run_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sh    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= opcode;
      s1_a     <= input1;
      s1_b     <= input2;
      s1_sh    <= shiftValue;
    end else if (alu_fire || mul_fire) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags_q   <= '0;
    end else if (alu_fire) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      flags_q   <= alu_flags;
    end else if (mul_fire) begin
      out_valid <= 1'b1;
      result    <= mul_res;
      flags_q   <= mul_flags;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign carryFlag   = flags_q.carry;
  assign zeroFlag    = flags_q.zero;
  assign signFlag    = flags_q.sign;
  assign ovfFlag     = flags_q.ovf;
  assign illegalFlag = flags_q.illegal;

endmodule

// File: doc/alu_pipe_hs.md
ALU_PIPE_HS -- requirements
Module: alu_pipe_hs

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (>=8, power of two).
REQ-002 SHALL derive parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1: upstream handshake.
REQ-006 SHALL have ports opcode input 4, input1 input WIDTH, input2 input WIDTH, shiftValue input SHW: operation request.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1: downstream handshake.
REQ-008 SHALL have outputs result WIDTH, carryFlag 1, zeroFlag 1, signFlag 1, ovfFlag 1, illegalFlag 1, all registered.

Function
REQ-009 SHALL accept a request on a rising edge with in_valid=1 and in_ready=1; operands and opcode are captured into stage-1 registers on that edge.
REQ-010 SHALL load result and flags into the output register on the next edge after accept (single-cycle ops); out_valid=1 from that edge.
REQ-011 SHALL hold result, flags and out_valid stable while out_valid=1 and out_ready=0.
REQ-012 SHALL drive in_ready=1 when stage 1 is empty, or stage 1 holds a single-cycle op and the output register is empty or being drained this cycle; 0 while the multiplier is running.
REQ-013 SHALL sustain one transaction per cycle with out_ready held 1 and no MUL.
REQ-014 SHALL implement opcodes: 0 ADD, 1 SUB, 2 MUL, 3 SLT (signed), 4 ROR, 5 SNE, 6 AND, 7 SGE (signed), 8 OR, 9 XOR, 10 ROL, 11 SLTU.
REQ-015 SHALL, for ADD, set carryFlag = carry-out of WIDTH-bit add; ovfFlag = signed overflow.
REQ-016 SHALL, for SUB, set carryFlag = 1 when input1 < input2 unsigned (borrow); ovfFlag = signed overflow.
REQ-017 SHALL, for compares (SLT, SNE, SGE, SLTU), produce result = {WIDTH-1 zeros, cond}.
REQ-018 SHALL rotate by shiftValue mod WIDTH for ROR/ROL; shiftValue=0 returns input1 unchanged.
REQ-019 SHALL set zeroFlag = (result==0) and signFlag = result[WIDTH-1] for every op; carryFlag and ovfFlag = 0 for ops other than ADD, SUB, MUL.
REQ-020 SHALL, for opcodes 12-15, produce result=0, illegalFlag=1, zeroFlag=1, other flags 0, with single-cycle latency.

Reset
REQ-021 SHALL, while rst=0, clear stage-1 registers, the multiplier state, result, all flags and out_valid; in_ready=0 during reset.
REQ-022 SHALL abort any in-flight operation, including a running MUL, on reset assertion; no partial result is ever presented.
REQ-023 SHALL drive in_ready=1 on the first edge after rst deasserts.

Configuration
REQ-024 SHALL, with macro ALU_PIPE_HS_MUL_EN defined, implement MUL as an iterative shift-add multiplier: FSM IDLE -> RUN (WIDTH cycles, bit counter 0..WIDTH-1) -> DONE (writes output register when free) -> IDLE.
REQ-025 SHALL, in MUL, return the low WIDTH bits of the unsigned product and set carryFlag=1 when the high WIDTH bits are nonzero; ovfFlag=0.
REQ-026 SHALL, in DONE with out_valid=1 and out_ready=0, hold the product until the output register drains.
REQ-027 SHALL, without ALU_PIPE_HS_MUL_EN, treat opcode 2 as illegal per REQ-020 and contain no multiplier logic.

Structure
REQ-028 SHALL take opcode localparams and the MUL FSM state enum from shared package alu_pipe_hs_pkg.
REQ-029 SHALL place the iterative multiplier in sub-module alu_mul_iter (start/busy/done, WIDTH parameter), instantiated only under ALU_PIPE_HS_MUL_EN.

Verification (WIDTH=32)
REQ-030 SHALL check ADD 0xFFFFFFFF+0x00000001 -> result 0, carryFlag=1, zeroFlag=1, ovfFlag=0, one edge after accept.
REQ-031 SHALL check SUB 0x80000000-0x00000001 -> result 0x7FFFFFFF, ovfFlag=1, carryFlag=0; SLT 0xFFFFFFFF,0x00000001 -> 1; SLTU same operands -> 0.
REQ-032 SHALL check ROR 0x00000001 by 1 -> 0x80000000, signFlag=1; ROL 0x80000000 by 1 -> 0x00000001.
REQ-033 SHALL check back-to-back ADDs with out_ready=0 for 3 cycles: in_ready drops, no result lost or duplicated, order preserved.
REQ-034 SHALL check, with MUL_EN, MUL 0x00010000*0x00010000 -> result 0, carryFlag=1, after 32 busy cycles; without MUL_EN -> illegalFlag=1.
REQ-035 SHALL check rst=0 mid-MUL (cycle 10) -> out_valid=0, all outputs 0; next ADD 2+3 -> 5.
